// File: rtl/fan_pkg.sv
// Shared types for the fan speed controller and its sequencer: speed codes and sequencer states.
package fan_pkg;

  typedef logic [1:0] speed_t;

  localparam speed_t SpeedStop = 2'd0;
  localparam speed_t SpeedSlow = 2'd1;
  localparam speed_t SpeedMed  = 2'd2;
  localparam speed_t SpeedFast = 2'd3;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StStep = 2'd1,
    StWait = 2'd2
  } seq_state_e;

  // Number of asserted flags among three, as a speed level.
  function automatic speed_t count3(input logic a, input logic b, input logic c);
    return speed_t'({1'b0, a}) + speed_t'({1'b0, b}) + speed_t'({1'b0, c});
  endfunction

endpackage

// File: rtl/temp_quantizer.sv
// Quantizes temperature samples into a 0..3 speed level, with hysteresis on the way down.
module temp_quantizer
  import fan_pkg::*;
#(
  parameter int unsigned TEMP_W = 8,
  parameter int unsigned T1     = 40,
  parameter int unsigned T2     = 60,
  parameter int unsigned T3     = 80,
  parameter int unsigned HYST   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              temp_valid,
  input  logic [TEMP_W-1:0] temp,
  output speed_t            auto_tgt
);

  localparam logic [TEMP_W-1:0] ThUp1 = TEMP_W'(T1);
  localparam logic [TEMP_W-1:0] ThUp2 = TEMP_W'(T2);
  localparam logic [TEMP_W-1:0] ThUp3 = TEMP_W'(T3);
  localparam logic [TEMP_W-1:0] ThDn1 = TEMP_W'(T1 - HYST);
  localparam logic [TEMP_W-1:0] ThDn2 = TEMP_W'(T2 - HYST);
  localparam logic [TEMP_W-1:0] ThDn3 = TEMP_W'(T3 - HYST);

  speed_t auto_q, auto_d;
  speed_t lvl_up, lvl_dn;

  always_comb begin
    lvl_up = count3(temp >= ThUp1, temp >= ThUp2, temp >= ThUp3);
    lvl_dn = count3(temp >= ThDn1, temp >= ThDn2, temp >= ThDn3);
    auto_d = auto_q;
    if (temp_valid) begin
      if (lvl_up > auto_q) begin
        auto_d = lvl_up;
      end else if (lvl_dn < auto_q) begin
        auto_d = lvl_dn;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      auto_q <= SpeedStop;
    end else begin
      auto_q <= auto_d;
    end
  end

  assign auto_tgt = auto_q;

endmodule

// File: rtl/fan_sequencer.sv
// Walks the fan controller one step at a time toward an auto or manual target, dwelling between
// steps.
module fan_sequencer
  import fan_pkg::*;
#(
  parameter int unsigned TEMP_W       = 8,
  parameter int unsigned T1           = 40,
  parameter int unsigned T2           = 60,
  parameter int unsigned T3           = 80,
  parameter int unsigned HYST         = 4,
  parameter int unsigned DWELL_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              temp_valid,
  input  logic [TEMP_W-1:0] temp,
  input  logic              man_en,
  input  logic              man_up,
  input  logic              man_down,
  input  logic [1:0]        speed_in,
  output logic              update,
  output logic              up,
  output logic              down,
  output logic [1:0]        target,
  output logic              busy
);

  localparam int unsigned CntW = $clog2(DWELL_CYCLES + 1);

  speed_t     auto_tgt;
  speed_t     man_q, man_d;
  logic       man_en_q;
  seq_state_e state_q, state_d;
  logic       dir_q, dir_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  temp_quantizer #(
    .TEMP_W(TEMP_W),
    .T1    (T1),
    .T2    (T2),
    .T3    (T3),
    .HYST  (HYST)
  ) u_quant (
    .clk       (clk),
    .reset     (reset),
    .temp_valid(temp_valid),
    .temp      (temp),
    .auto_tgt  (auto_tgt)
  );

  // Entering manual mode starts from the current speed so the fan does not jump.
  always_comb begin
    man_d = man_q;
    if (man_en && !man_en_q) begin
      man_d = speed_in;
    end else if (man_en) begin
      if (man_up && !man_down && man_q != SpeedFast) begin
        man_d = man_q + 2'd1;
      end else if (man_down && !man_up && man_q != SpeedStop) begin
        man_d = man_q - 2'd1;
      end
    end
  end

  assign target = man_en ? man_q : auto_tgt;

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    update  = 1'b0;
    up      = 1'b0;
    down    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (target != speed_in) begin
          dir_d   = target > speed_in;
          state_d = StStep;
        end
      end
      StStep: begin
        update  = 1'b1;
        up      = dir_q;
        down    = ~dir_q;
        cnt_d   = CntW'(DWELL_CYCLES - 1);
        state_d = StWait;
      end
      StWait: begin
        if (cnt_q == '0) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign busy = state_q != StIdle;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      dir_q    <= 1'b0;
      cnt_q    <= '0;
      man_q    <= SpeedStop;
      man_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      dir_q    <= dir_d;
      cnt_q    <= cnt_d;
      man_q    <= man_d;
      man_en_q <= man_en;
    end
  end

endmodule

// File: tb/tb_fan_sequencer.sv
// Closed-loop bench: fan controller model in the loop, timer-based reference model, directed
// scenarios followed by randomized stimulus.
module tb_fan_sequencer;

  localparam int T1 = 40, T2 = 60, T3 = 80, HYST = 4, DWELL = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       temp_valid = 1'b0;
  logic [7:0] temp = 8'd0;
  logic       man_en = 1'b0, man_up = 1'b0, man_down = 1'b0;
  logic [1:0] speed = 2'd0;
  logic       update, up, down, busy;
  logic [1:0] target;

  int vectors = 0, miscompares = 0;
  int cyc = 0;
  bit chk = 0;

  // Reference model: target registers plus a countdown of remaining busy cycles.
  int m_auto = 0, m_man = 0, m_phase = 0;
  bit m_prev = 0, m_dir = 0;

  int st_cyc[$];
  bit st_up[$];

  fan_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .temp_valid(temp_valid),
    .temp      (temp),
    .man_en    (man_en),
    .man_up    (man_up),
    .man_down  (man_down),
    .speed_in  (speed),
    .update    (update),
    .up        (up),
    .down      (down),
    .target    (target),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic int lvl(input int t, input int off);
    int n = 0;
    if (t >= T1 - off) n++;
    if (t >= T2 - off) n++;
    if (t >= T3 - off) n++;
    return n;
  endfunction

  function automatic int mtgt();
    return man_en ? m_man : m_auto;
  endfunction

  task automatic check(input string name, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, got, exp);
    end
  endtask

  // Fan controller and reference model advance on the same edge as the DUT.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (update && up && speed != 2'd3) speed <= speed + 2'd1;
    else if (update && down && speed != 2'd0) speed <= speed - 2'd1;
    if (reset) begin
      m_auto <= 0; m_man <= 0; m_prev <= 0; m_phase <= 0;
    end else begin
      if (temp_valid) begin
        if (lvl(int'(temp), 0) > m_auto) m_auto <= lvl(int'(temp), 0);
        else if (lvl(int'(temp), HYST) < m_auto) m_auto <= lvl(int'(temp), HYST);
      end
      if (man_en && !m_prev) m_man <= int'(speed);
      else if (man_en && man_up && !man_down) m_man <= (m_man == 3) ? 3 : m_man + 1;
      else if (man_en && man_down && !man_up) m_man <= (m_man == 0) ? 0 : m_man - 1;
      m_prev <= man_en;
      if (m_phase > 0) m_phase <= m_phase - 1;
      else if (mtgt() != int'(speed)) begin
        m_phase <= DWELL + 1;
        m_dir   <= mtgt() > int'(speed);
      end
    end
  end

  always @(negedge clk) begin
    if (chk) begin
      check("update", int'(update), int'(m_phase == DWELL + 1));
      check("up", int'(up), int'(m_phase == DWELL + 1 && m_dir));
      check("down", int'(down), int'(m_phase == DWELL + 1 && !m_dir));
      check("busy", int'(busy), int'(m_phase > 0));
      check("target", int'(target), mtgt());
      if (update) begin
        st_cyc.push_back(cyc);
        st_up.push_back(up);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply_temp(input int t);
    temp_valid = 1'b1;
    temp = 8'(t);
    tick(1);
    temp_valid = 1'b0;
  endtask

  task automatic settle();
    int n = 0;
    while (!(busy == 1'b0 && target == speed) && n < 300) begin
      tick(1);
      n++;
    end
    if (n >= 300) check("settle_timeout", 1, 0);
  endtask

  task automatic wait_wait_at(input int spd);
    int n = 0;
    while (!(busy && update == 1'b0 && int'(speed) == spd) && n < 100) begin
      tick(1);
      n++;
    end
    if (n >= 100) check("wait_timeout", 1, 0);
  endtask

  initial begin
    tick(3);
    chk = 1;
    check("rst_busy", int'(busy), 0);
    check("rst_update", int'(update), 0);
    check("rst_target", int'(target), 0);
    reset = 1'b0;
    tick(2);
    check("idle_busy", int'(busy), 0);
    check("idle_target", int'(target), 0);

    // Auto ramp to MED
    st_cyc.delete(); st_up.delete();
    apply_temp(65);
    check("ramp_target", int'(target), 2);
    settle();
    check("ramp_speed", int'(speed), 2);
    check("ramp_strobes", st_cyc.size(), 2);
    if (st_cyc.size() == 2) begin
      check("ramp_spacing", st_cyc[1] - st_cyc[0], DWELL + 2);
      check("ramp_dir", int'(st_up[0] && st_up[1]), 1);
    end

    // Hysteresis
    apply_temp(58);
    check("hyst58", int'(target), 2);
    st_cyc.delete(); st_up.delete();
    apply_temp(55);
    check("hyst55", int'(target), 1);
    settle();
    check("hyst55_strobes", st_cyc.size(), 1);
    check("hyst55_speed", int'(speed), 1);
    apply_temp(57);
    check("hyst57", int'(target), 1);
    apply_temp(60);
    check("hyst60", int'(target), 2);
    settle();

    // Manual override, entered while the step down to SLOW is dwelling
    apply_temp(40);
    wait_wait_at(1);
    man_en = 1'b1;
    tick(1);
    check("man_load", int'(target), 1);
    apply_temp(0);
    check("man_hold", int'(target), 1);
    settle();
    st_cyc.delete(); st_up.delete();
    for (int i = 0; i < 3; i++) begin
      man_up = 1'b1; tick(1); man_up = 1'b0; tick(1);
    end
    check("man_sat", int'(target), 3);
    man_up = 1'b1; man_down = 1'b1; tick(1); man_up = 1'b0; man_down = 1'b0;
    check("man_both", int'(target), 3);
    settle();
    check("man_speed", int'(speed), 3);
    check("man_strobes", st_cyc.size(), 2);
    man_en = 1'b0;
    tick(1);
    check("man_exit", int'(target), 0);
    settle();
    check("man_exit_speed", int'(speed), 0);

    // Reversal mid-dwell
    st_cyc.delete(); st_up.delete();
    apply_temp(45);
    wait_wait_at(1);
    apply_temp(0);
    check("rev_target", int'(target), 0);
    settle();
    check("rev_strobes", st_cyc.size(), 2);
    if (st_cyc.size() == 2) begin
      check("rev_spacing", st_cyc[1] - st_cyc[0], DWELL + 2);
      check("rev_dirs", int'({st_up[0], st_up[1]}), 2);
    end

    // Reset in the third dwell cycle
    apply_temp(45);
    for (int n = 0; n < 10 && !update; n++) tick(1);
    check("pre_rst_update", int'(update), 1);
    tick(3);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check("wrst_busy", int'(busy), 0);
    check("wrst_update", int'(update), 0);
    check("wrst_target", int'(target), 0);
    settle();

    // Randomized closed-loop run
    for (int i = 0; i < 5000; i++) begin
      reset = ($urandom_range(0, 799) == 0);
      temp_valid = ($urandom_range(0, 14) == 0);
      case ($urandom_range(0, 2))
        0: temp = 8'($urandom_range(0, 255));
        1: temp = 8'(T1 + 20 * $urandom_range(0, 2) - 6 + $urandom_range(0, 10));
        default: temp = 8'($urandom_range(30, 90));
      endcase
      if ($urandom_range(0, 119) == 0) man_en = ~man_en;
      man_up = ($urandom_range(0, 11) == 0);
      man_down = ($urandom_range(0, 11) == 0);
      tick(1);
    end
    reset = 1'b0; temp_valid = 1'b0; man_up = 1'b0; man_down = 1'b0;
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fan_sequencer.md
# fan_sequencer

Closed-loop sequencer that drives the fan speed controller's `update`/`up`/`down` command inputs. It quantizes periodic temperature samples into a target speed level, using hysteresis on the way down, and lets a manual override replace that target. It then walks the fan controller toward the target one step at a time, with a guaranteed dwell between steps. It sits between the temperature-sensor interface and the fan speed controller, and reads the controller's `speed` output back as `speed_in`.

## Interface
- `TEMP_W`, 8: temperature sample width (unsigned).
- `T1`, 40: threshold for level 1 (slow).
- `T2`, 60: threshold for level 2 (med).
- `T3`, 80: threshold for level 3 (fast). Constraint: HYST < T1 < T2 < T3 < 2^TEMP_W.
- `HYST`, 4: downward hysteresis, in temperature units.
- `DWELL_CYCLES`, 16: WAIT length after each step. Constraint: ≥ 1.

Ports:
- `clk`, in, 1: clock.
- `reset`, in, 1: reset, synchronous, active-high.
- `temp_valid`, in, 1: one-cycle strobe qualifying `temp`.
- `temp`, in, TEMP_W: temperature sample.
- `man_en`, in, 1: manual override enable (level).
- `man_up`, in, 1: manual increment request (one-cycle pulse).
- `man_down`, in, 1: manual decrement request (one-cycle pulse).
- `speed_in`, in, 2: current speed reported by the fan controller.
- `update`, out, 1: command strobe to the fan controller.
- `up`, out, 1: step-up command.
- `down`, out, 1: step-down command.
- `target`, out, 2: effective target speed, after manual/auto selection.
- `busy`, out, 1: high in STEP or WAIT.

## Operation
- Auto target `auto_tgt` (2-bit register), updated only on cycles with `temp_valid`:
  - `lvl_up` = number of thresholds k with `temp` ≥ Tk.
  - `lvl_dn` = number of thresholds k with `temp` ≥ Tk−HYST.
  - If `lvl_up` > `auto_tgt`: `auto_tgt` ← `lvl_up`.
  - Else if `lvl_dn` < `auto_tgt`: `auto_tgt` ← `lvl_dn`.
  - Else hold.
  - Multi-level jumps are allowed in one sample.
- Manual target `man_tgt` (2-bit register):
  - On a `man_en` rising edge: `man_tgt` ← `speed_in`.
  - While `man_en` is high: `man_up` alone increments, saturating at 3; `man_down` alone decrements, saturating at 0; both together are ignored.
- `target` = `man_tgt` if `man_en`, else `auto_tgt`. This is a combinational select of two registers.
- FSM states: IDLE, STEP, WAIT.
  - IDLE: if `target` ≠ `speed_in`, latch `dir` = (`target` > `speed_in`) and go to STEP; else stay.
  - STEP: lasts exactly 1 cycle. `update` = 1, `up` = `dir`, `down` = ~`dir`. Load the dwell counter with DWELL_CYCLES−1 and go to WAIT.
  - WAIT: decrement the counter; when it reads 0, go to IDLE.
  - Counter width: $clog2(DWELL_CYCLES+1).
- Outputs outside STEP: `update` = `up` = `down` = 0. `up` and `down` are never both high.
- Target changes during STEP or WAIT do not abort the step. They are re-evaluated in IDLE, so direction reversal takes effect only after the dwell.
- Reset values: state IDLE; `auto_tgt` = 0; `man_tgt` = 0; counter 0; previous-`man_en` register 0.
  - Output consequences: `update`/`up`/`down` = 0, `busy` = 0, `target` = 0.
  - Reset overrides every other input in that cycle. Reset in STEP or WAIT returns to IDLE with no further strobe.

## Timing
- `temp_valid` at cycle n → `auto_tgt` visible at n+1 → IDLE comparison at n+1 → STEP (`update` high) at n+2.
- The fan controller updates `speed` at the clock edge ending STEP, so `speed_in` is valid before WAIT ends.
- Step period, IDLE → STEP → WAIT → IDLE:
  - DWELL_CYCLES+1 cycles per step, plus 1 IDLE cycle between steps.
  - Consecutive `update` strobes are spaced DWELL_CYCLES+2 cycles apart (18 at default).
- Manual pulse at cycle n → `man_tgt` at n+1 → `update` at n+2 when IDLE.

## Structure
- Shared package `fan_pkg`:
  - Speed codes STOP = 0, SLOW = 1, MED = 2, FAST = 3.
  - Sequencer state encoding IDLE/STEP/WAIT.
  - A 2-bit speed typedef, used by both this block and the fan controller.
- Sub-module `temp_quantizer`: the threshold/hysteresis logic plus the `auto_tgt` register, with ports `clk`, `reset`, `temp_valid`, `temp` → `auto_tgt`.
- Top level holds the manual logic, the FSM, the dwell counter and the output decode.

## Test plan
- Reset with `speed_in` = 0, `temp` = 0 → `update`/`up`/`down`/`busy` = 0 and `target` = 0 during reset and after release; no strobe.
- Auto ramp up, with the fan controller model in the loop: one `temp_valid` with `temp` = 65 → `target` = 2 next cycle, then one up strobe each to speed 1 and speed 2, with the second 18 cycles after the first; then idle.
- Hysteresis, from target 2:
  - `temp` = 58 → hold at 2.
  - `temp` = 55 → target 1 and a single down strobe.
  - `temp` = 57 → hold at 1.
  - `temp` = 60 → target 2.
- Manual override at speed 1: `man_en` rises → `man_tgt` = 1. Then:
  - `man_up` ×3 → target saturates at 3, with two up strobes.
  - `man_up` and `man_down` in the same cycle → no change.
  - `man_en` falls with `auto_tgt` = 0 → steps down to 0.
- Reversal mid-dwell: during WAIT after an up step, `target` drops below `speed_in` → no strobe until WAIT expires, then a down strobe.
- Reset asserted in the third WAIT cycle → `busy` = 0 next cycle, no `update`, `auto_tgt` = 0.
